// File: rtl/game_tick_scheduler_if.sv
// Control/status bundle between game logic and the shared tick scheduler.
interface game_tick_scheduler_if #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned PERIOD_W = 16
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [PERIOD_W-1:0] cfg_period;
    logic                cfg_oneshot;
    logic [NUM_CH-1:0]   start;
    logic [NUM_CH-1:0]   stop;
    logic                base_tick;
    logic [NUM_CH-1:0]   tick;
    logic [NUM_CH-1:0]   running;
    logic [NUM_CH-1:0]   done;

    modport master (
        output cfg_we, cfg_ch, cfg_period, cfg_oneshot, start, stop,
        input  base_tick, tick, running, done
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_period, cfg_oneshot, start, stop,
        output base_tick, tick, running, done
    );
endinterface

// File: rtl/game_tick_scheduler.sv
// Shared timebase: one prescaler producing base_tick, plus NUM_CH
// periodic/one-shot channels that count base ticks and emit 1-cycle enables.
module game_tick_scheduler #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                 clk_in,
    input  logic                 reset,
    game_tick_scheduler_if.slave bus
);
    localparam int unsigned PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PCNT_W-1:0]   PCNT_LAST  = PCNT_W'(PRESCALE - 1);
    localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_t;

    logic [PCNT_W-1:0]   pcount;
    logic                base_tick_c;
    logic [PERIOD_W-1:0] cfg_period_eff_c;
    logic [NUM_CH-1:0]   cfg_hit_c;

    ch_state_t           state         [NUM_CH];
    ch_state_t           state_nxt     [NUM_CH];
    logic [PERIOD_W-1:0] remaining     [NUM_CH];
    logic [PERIOD_W-1:0] remaining_nxt [NUM_CH];
    logic [PERIOD_W-1:0] period        [NUM_CH];
    logic [PERIOD_W-1:0] period_nxt    [NUM_CH];
    logic [NUM_CH-1:0]   oneshot;
    logic [NUM_CH-1:0]   oneshot_nxt;
    logic [NUM_CH-1:0]   mode;
    logic [NUM_CH-1:0]   mode_nxt;
    logic [NUM_CH-1:0]   tick_q;
    logic [NUM_CH-1:0]   tick_nxt;
    logic [NUM_CH-1:0]   run_dec;
    logic [NUM_CH-1:0]   done_dec;

    // Free-running prescaler, independent of channel activity
    always_ff @(posedge clk_in) begin
        if (reset) begin
            pcount <= '0;
        end else if (pcount == PCNT_LAST) begin
            pcount <= '0;
        end else begin
            pcount <= pcount + PCNT_W'(1);
        end
    end

    assign base_tick_c      = (pcount == PCNT_LAST);
    assign cfg_period_eff_c = (bus.cfg_period == '0) ? PERIOD_ONE : bus.cfg_period;

    // Decode which channel a config write targets; out-of-range indices hit nothing
    always_comb begin
        cfg_hit_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_hit_c[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
        end
    end

    // Channel next-state: stop beats start beats countdown/expiry
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_nxt[i]     = state[i];
            remaining_nxt[i] = remaining[i];
            period_nxt[i]    = period[i];
        end
        oneshot_nxt = oneshot;
        mode_nxt    = mode;
        tick_nxt    = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_hit_c[i]) begin
                period_nxt[i]  = cfg_period_eff_c;
                oneshot_nxt[i] = bus.cfg_oneshot;
            end

            if (bus.stop[i]) begin
                state_nxt[i] = ST_IDLE;
            end else if (bus.start[i]) begin
                // same-cycle config write is visible to the load
                state_nxt[i]     = ST_RUN;
                remaining_nxt[i] = period_nxt[i];
                mode_nxt[i]      = oneshot_nxt[i];
            end else if ((state[i] == ST_RUN) && base_tick_c) begin
                if (remaining[i] > PERIOD_ONE) begin
                    remaining_nxt[i] = remaining[i] - PERIOD_ONE;
                end else begin
                    tick_nxt[i] = 1'b1;
                    if (mode[i]) begin
                        state_nxt[i] = ST_DONE;
                    end else begin
                        remaining_nxt[i] = period_nxt[i];
                    end
                end
            end
        end
    end

    // Channel state, config and tick registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]     <= ST_IDLE;
                remaining[i] <= '0;
                period[i]    <= PERIOD_ONE;
            end
            oneshot <= '0;
            mode    <= '0;
            tick_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]     <= state_nxt[i];
                remaining[i] <= remaining_nxt[i];
                period[i]    <= period_nxt[i];
            end
            oneshot <= oneshot_nxt;
            mode    <= mode_nxt;
            tick_q  <= tick_nxt;
        end
    end

    // Status flags decoded from the registered channel state
    always_comb begin
        run_dec  = '0;
        done_dec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            run_dec[i]  = (state[i] == ST_RUN);
            done_dec[i] = (state[i] == ST_DONE);
        end
    end

    assign bus.base_tick = base_tick_c;
    assign bus.tick      = tick_q;
    assign bus.running   = run_dec;
    assign bus.done      = done_dec;
endmodule

// File: tb/tb_game_tick_scheduler.sv
// Scoreboard bench for game_tick_scheduler with PRESCALE=4.
// A second 3-channel instance exercises writes to a nonexistent channel.
module tb_game_tick_scheduler;
    localparam int PRESCALE = 4;

    typedef struct {
        int cyc;
        int ch;
    } tick_exp_t;

    typedef struct {
        int         cyc;
        logic [3:0] run;
        logic [3:0] dn;
        logic       bt;
    } stat_exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    tick_exp_t tick_q[$];
    stat_exp_t stat_q[$];
    tick_exp_t te;
    stat_exp_t se;

    game_tick_scheduler_if #(.NUM_CH(4), .PERIOD_W(16)) bus  ();
    game_tick_scheduler_if #(.NUM_CH(3), .PERIOD_W(16)) bus3 ();

    game_tick_scheduler #(.PRESCALE(4), .NUM_CH(4), .PERIOD_W(16)) u_dut (
        .clk_in (clk),
        .reset  (reset),
        .bus    (bus)
    );

    game_tick_scheduler #(.PRESCALE(4), .NUM_CH(3), .PERIOD_W(16)) u_dut3 (
        .clk_in (clk),
        .reset  (reset),
        .bus    (bus3)
    );

    always #5 clk = ~clk;

    // cycle 1 = first cycle with reset low
    always @(posedge clk) cyc <= reset ? 1 : cyc + 1;

    // Monitor: pop and compare whenever the DUTs present a tick or a status sample is due
    always @(negedge clk) begin
        logic [6:0] all_tick;
        all_tick = {bus3.tick, bus.tick};
        for (int b = 0; b < 7; b++) begin
            if (all_tick[b] === 1'b1) begin
                checks++;
                if (tick_q.size() == 0) begin
                    errors++;
                    $display("FAIL tick_unexpected cyc=%0d ch=%0d", cyc, b);
                end else begin
                    te = tick_q.pop_front();
                    if (te.cyc != cyc || te.ch != b) begin
                        errors++;
                        $display("FAIL tick got cyc=%0d ch=%0d expected cyc=%0d ch=%0d",
                                 cyc, b, te.cyc, te.ch);
                    end
                end
            end
        end
        if (stat_q.size() > 0 && stat_q[0].cyc == cyc) begin
            se = stat_q.pop_front();
            checks++;
            if (bus.running !== se.run || bus.done !== se.dn || bus.base_tick !== se.bt) begin
                errors++;
                $display("FAIL status cyc=%0d got run=%b done=%b bt=%b expected run=%b done=%b bt=%b",
                         cyc, bus.running, bus.done, bus.base_tick, se.run, se.dn, se.bt);
            end
        end
    end

    function automatic void exp_tick(input int c, input int ch);
        tick_exp_t t;
        t.cyc = c;
        t.ch  = ch;
        tick_q.push_back(t);
    endfunction

    function automatic void exp_stat(input int c, input logic [3:0] r, input logic [3:0] d);
        stat_exp_t s;
        s.cyc = c;
        s.run = r;
        s.dn  = d;
        s.bt  = ((c % PRESCALE) == 0);
        stat_q.push_back(s);
    endfunction

    task automatic clear_strobes();
        bus.cfg_we  = 1'b0;
        bus.start   = '0;
        bus.stop    = '0;
        bus3.cfg_we = 1'b0;
        bus3.start  = '0;
        bus3.stop   = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic goto_cycle(input int n);
        int budget;
        budget = 200;
        while (cyc != n && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL goto_cycle reached=%0d wanted=%0d", cyc, n);
        end
    endtask

    task automatic cfg(input int ch, input int per, input logic os);
        bus.cfg_we      = 1'b1;
        bus.cfg_ch      = 2'(ch);
        bus.cfg_period  = 16'(per);
        bus.cfg_oneshot = os;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 100;
        while ((tick_q.size() != 0 || stat_q.size() != 0) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (tick_q.size() != 0 || stat_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending ticks=%0d status=%0d", tick_q.size(), stat_q.size());
            tick_q.delete();
            stat_q.delete();
        end
    endtask

    initial begin
        bus.cfg_ch       = '0;
        bus.cfg_period   = '0;
        bus.cfg_oneshot  = 1'b0;
        bus3.cfg_ch      = '0;
        bus3.cfg_period  = '0;
        bus3.cfg_oneshot = 1'b0;
        clear_strobes();

        // Reset values and prescaler cadence
        do_reset();
        for (int c = 1; c <= 13; c++) exp_stat(c, 4'b0000, 4'b0000);
        goto_cycle(16);
        drain();

        // Periodic channel 0, period 3, written and started together
        do_reset();
        exp_stat(1,  4'b0000, 4'b0000);
        exp_stat(2,  4'b0001, 4'b0000);
        exp_stat(4,  4'b0001, 4'b0000);
        exp_stat(13, 4'b0001, 4'b0000);
        exp_stat(39, 4'b0000, 4'b0000);
        exp_tick(13, 0);
        exp_tick(25, 0);
        exp_tick(37, 0);
        cfg(0, 3, 1'b0);
        bus.start = 4'b0001;
        next_cycle();
        goto_cycle(38);
        bus.stop = 4'b0001;
        next_cycle();
        goto_cycle(52);
        drain();

        // One-shot channel 1, period 2, then restart
        do_reset();
        exp_stat(2,  4'b0010, 4'b0000);
        exp_stat(8,  4'b0010, 4'b0000);
        exp_stat(9,  4'b0000, 4'b0010);
        exp_stat(12, 4'b0000, 4'b0010);
        exp_stat(15, 4'b0010, 4'b0000);
        exp_stat(21, 4'b0000, 4'b0010);
        exp_tick(9, 1);
        exp_tick(21, 1);
        cfg(1, 2, 1'b1);
        bus.start = 4'b0010;
        next_cycle();
        goto_cycle(14);
        bus.start = 4'b0010;
        next_cycle();
        goto_cycle(30);
        drain();

        // Conflicts on channel 2 (period 2)
        do_reset();
        exp_stat(3,  4'b0000, 4'b0000);
        exp_stat(4,  4'b0100, 4'b0000);
        exp_stat(9,  4'b0000, 4'b0000);
        exp_stat(17, 4'b0100, 4'b0000);
        exp_stat(35, 4'b0000, 4'b0000);
        exp_tick(25, 2);
        exp_tick(33, 2);
        cfg(2, 2, 1'b0);
        next_cycle();
        bus.start = 4'b0100;
        bus.stop  = 4'b0100;
        next_cycle();
        bus.start = 4'b0100;
        next_cycle();
        goto_cycle(8);
        bus.stop = 4'b0100;
        next_cycle();
        bus.start = 4'b0100;
        next_cycle();
        goto_cycle(16);
        bus.start = 4'b0100;
        next_cycle();
        goto_cycle(34);
        bus.stop = 4'b0100;
        next_cycle();
        goto_cycle(44);
        drain();

        // Config edge cases: period 0, rewrite while running, out-of-range channel
        do_reset();
        for (int c = 5; c <= 33; c += 4) begin
            if (c == 13 || c >= 25) exp_tick(c, 0);
            exp_tick(c, 3);
            if (c <= 9) begin
                exp_tick(c, 4);
                exp_tick(c, 5);
                exp_tick(c, 6);
            end
        end
        exp_stat(2,  4'b1000, 4'b0000);
        exp_stat(4,  4'b1001, 4'b0000);
        exp_stat(35, 4'b0000, 4'b0000);
        cfg(3, 0, 1'b0);
        bus.start        = 4'b1000;
        bus3.cfg_we      = 1'b1;
        bus3.cfg_ch      = 2'd3;
        bus3.cfg_period  = 16'd7;
        bus3.cfg_oneshot = 1'b1;
        next_cycle();
        cfg(0, 3, 1'b0);
        bus3.start = 3'b111;
        next_cycle();
        bus.start = 4'b0001;
        next_cycle();
        goto_cycle(10);
        bus3.stop = 3'b111;
        next_cycle();
        goto_cycle(14);
        cfg(0, 1, 1'b0);
        next_cycle();
        goto_cycle(34);
        bus.stop = 4'b1001;
        next_cycle();
        goto_cycle(44);
        drain();

        // Reset asserted in the expiry cycle with all channels running
        do_reset();
        exp_stat(5, 4'b1111, 4'b0000);
        cfg(0, 3, 1'b0);
        bus.start = 4'b0001;
        next_cycle();
        cfg(1, 3, 1'b0);
        bus.start = 4'b0010;
        next_cycle();
        cfg(2, 3, 1'b0);
        bus.start = 4'b0100;
        next_cycle();
        cfg(3, 3, 1'b0);
        bus.start = 4'b1000;
        next_cycle();
        goto_cycle(12);
        exp_stat(1, 4'b0000, 4'b0000);
        do_reset();
        for (int c = 2; c <= 9; c++) exp_stat(c, 4'b0000, 4'b0000);
        goto_cycle(20);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/game_tick_scheduler.md
# game_tick_scheduler

Shared timebase controller for the game logic: one free-running prescaler on `clk_in` produces a base tick, and NUM_CH independently configurable channels count base ticks to emit one-cycle enable pulses (periodic or one-shot). Sprite animation, fall timers and countdowns use these pulses as clock enables instead of each instantiating its own divided clock, so the whole design stays on the single `clk_in` domain.

## Interface
- PRESCALE, 50000, `clk_in` cycles per base tick (≥2); 1 kHz base at 50 MHz
- NUM_CH, 4, number of channels (≥1)
- PERIOD_W, 16, width of the per-channel period in base ticks
- clk_in  in  1  sole clock; all state on its rising edge
- reset  in  1  synchronous, active-high; sampled on `clk_in` rising edge
- cfg_we  in  1  write strobe for channel configuration
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel; values ≥ NUM_CH ignored
- cfg_period  in  PERIOD_W  period in base ticks; 0 is treated as 1
- cfg_oneshot  in  1  1 = one-shot, 0 = periodic
- start  in  NUM_CH  per-channel start/restart request, 1 cycle
- stop  in  NUM_CH  per-channel stop request, 1 cycle
- base_tick  out  1  high 1 cycle every PRESCALE cycles
- tick  out  NUM_CH  per-channel expiry pulse, 1 cycle, registered
- running  out  NUM_CH  channel in RUN
- done  out  NUM_CH  sticky: one-shot channel has expired

## Operation
- Prescaler: `pcount` 0..PRESCALE-1, increments every cycle, wraps to 0 after PRESCALE-1; `base_tick` = (`pcount` == PRESCALE-1), decoded from the registered count. Free-running; unaffected by channel activity.
- Config registers per channel: `period[i]` (reset 1), `oneshot[i]` (reset 0). `cfg_we` writes channel `cfg_ch`; a stored 0 is held as 1. Write to a running channel does not alter the current countdown; new value used at next load.
- Per-channel FSM, states IDLE / RUN / DONE, plus `remaining[i]` (PERIOD_W bits):
  - IDLE/DONE + start → RUN, `remaining` ← `period`, `done` ← 0.
  - RUN + start → restart: `remaining` ← `period`; that cycle's base_tick is not counted and produces no tick.
  - RUN + base_tick, `remaining` > 1 → `remaining` − 1.
  - RUN + base_tick, `remaining` == 1 → `tick[i]` high next cycle; periodic: reload `period`, stay RUN; one-shot: → DONE, `done[i]` ← 1.
  - any state + stop → IDLE, `done` ← 0, no tick; stop wins over simultaneous start and over a simultaneous expiry.
- cfg_we and start on the same channel in the same cycle: start loads the new `cfg_period` value.
- `running[i]` = (state == RUN); `done[i]` = (state == DONE).

## Timing
- Reset: `pcount` 0, all channels IDLE, `remaining` 0, `period` 1, `oneshot` 0; `base_tick`, `tick`, `running`, `done` all 0 on the cycle after reset is sampled. Reset mid-run aborts all channels with no tick.
- First `base_tick` in the PRESCALE-th cycle after reset release (cycle 1 = first cycle with reset low); then every PRESCALE cycles.
- `running`/`done` update the cycle after the start/stop/expiry edge.
- Start → first tick: `tick[i]` asserted the cycle after the `period`-th base_tick strictly following the start cycle; periodic ticks then spaced exactly `period`×PRESCALE cycles.
- `tick[i]` is exactly one cycle wide; multiple channels may tick in the same cycle.
- `remaining` never wraps: decrement only when > 1.

## Test plan
- Reset/prescaler, PRESCALE=4: reset 3 cycles then release → all outputs 0; `base_tick` in cycles 4, 8, 12; none elsewhere.
- Periodic: PRESCALE=4, write ch0 period=3 periodic, start ch0 in cycle 1 → `tick[0]` in cycles 13, 25, 37; `running[0]`=1 from cycle 2.
- One-shot: ch1 period=2 one-shot, start in cycle 1 → single `tick[1]` in cycle 9, `done[1]`=1 and `running[1]`=0 from cycle 9; re-start clears `done[1]` and repeats.
- Conflicts: start+stop same cycle → stays IDLE; stop in the expiry base_tick cycle → no tick, IDLE; start in RUN on a base_tick cycle → countdown restarts, no tick.
- Config edge cases: period=0 → tick every base tick; rewrite ch0 period 3→1 while running → current interval still 3, following intervals 1; cfg_ch ≥ NUM_CH write changes nothing.
- Reset mid-operation: all 4 channels running, assert reset one cycle before expiry → no tick, all outputs 0, prescaler restarts at 0.
